// File: rtl/matrix_slot_allocator.sv
// matrix_slot_allocator: hands out fixed-size BRAM regions to (m,n) matrices, reusing the
// oldest same-shape slot when a shape hits its quota, else the lowest free, else the oldest.
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 10
`endif
module matrix_slot_allocator #(
    parameter int NUM_SLOTS  = 8,
    parameter int SLOT_SIZE  = 32,
    parameter int ADDR_WIDTH = `BRAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            config_max_per_dim,
    input  logic                  clear_all,
    input  logic                  alloc_req,
    input  logic [3:0]            alloc_m,
    input  logic [3:0]            alloc_n,
    output logic                  alloc_valid,
    output logic                  alloc_err,
    output logic [3:0]            alloc_slot,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic                  commit_req,
    input  logic [3:0]            commit_slot,
    input  logic [3:0]            commit_m,
    input  logic [3:0]            commit_n,
    input  logic [ADDR_WIDTH-1:0] commit_addr,
    output logic                  commit_err,
    input  logic [3:0]            query_slot,
    output logic                  query_valid,
    output logic [3:0]            query_m,
    output logic [3:0]            query_n,
    output logic [ADDR_WIDTH-1:0] query_addr,
    output logic [NUM_SLOTS-1:0]  slot_valid,
    output logic                  busy
);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = $clog2(NUM_SLOTS + 1);

    typedef enum logic [2:0] {IDLE, SCAN, DECIDE, GRANT, WAIT_RELEASE} state_t;

    state_t                r_state;
    logic [NUM_SLOTS-1:0]  r_valid, r_reserved;
    logic [3:0]            r_m [NUM_SLOTS];
    logic [3:0]            r_n [NUM_SLOTS];
    logic [7:0]            r_age [NUM_SLOTS];
    logic [3:0]            r_req_m, r_req_n;
    logic [SW-1:0]         r_idx;
    logic                  r_free_hit, r_match_hit, r_old_hit;
    logic [SW-1:0]         r_free_idx, r_match_idx, r_old_idx;
    logic [7:0]            r_match_age, r_old_age;
    logic [CW-1:0]         r_match_cnt;
    logic                  r_alloc_valid, r_alloc_err, r_commit_err, r_query_valid;
    logic [3:0]            r_alloc_slot, r_query_m, r_query_n;
    logic [ADDR_WIDTH-1:0] r_alloc_addr, r_query_addr;

    logic [3:0]    w_max;
    logic [7:0]    w_area;
    logic          w_bad, w_cur_match, w_commit_ok, w_q_ok, w_unused;
    logic [SW-1:0] w_victim, w_cslot, w_qslot;

    assign w_max       = (config_max_per_dim == 4'd0) ? 4'd1 : config_max_per_dim;
    assign w_area      = {4'd0, r_req_m} * {4'd0, r_req_n};
    assign w_bad       = (r_req_m == 4'd0) || (r_req_n == 4'd0) || (32'(w_area) > SLOT_SIZE);
    assign w_victim    = (32'(r_match_cnt) >= 32'(w_max)) ? r_match_idx :
                         r_free_hit ? r_free_idx : r_old_idx;
    assign w_cur_match = r_valid[r_idx] && r_m[r_idx] == r_req_m && r_n[r_idx] == r_req_n;
    assign w_cslot     = commit_slot[SW-1:0];
    assign w_commit_ok = (32'(commit_slot) < NUM_SLOTS) && r_reserved[w_cslot];
    assign w_qslot     = query_slot[SW-1:0];
    assign w_q_ok      = (32'(query_slot) < NUM_SLOTS) && r_valid[w_qslot];
    assign w_unused    = ^commit_addr;

    assign alloc_valid = r_alloc_valid;
    assign alloc_err   = r_alloc_err;
    assign alloc_slot  = r_alloc_slot;
    assign alloc_addr  = r_alloc_addr;
    assign commit_err  = r_commit_err;
    assign query_valid = r_query_valid;
    assign query_m     = r_query_m;
    assign query_n     = r_query_n;
    assign query_addr  = r_query_addr;
    assign slot_valid  = r_valid;
    assign busy        = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_valid       <= '0;
            r_reserved    <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_m[i]   <= '0;
                r_n[i]   <= '0;
                r_age[i] <= '0;
            end
            r_req_m       <= '0;
            r_req_n       <= '0;
            r_idx         <= '0;
            r_free_hit    <= 1'b0;
            r_match_hit   <= 1'b0;
            r_old_hit     <= 1'b0;
            r_free_idx    <= '0;
            r_match_idx   <= '0;
            r_old_idx     <= '0;
            r_match_age   <= '0;
            r_old_age     <= '0;
            r_match_cnt   <= '0;
            r_alloc_valid <= 1'b0;
            r_alloc_err   <= 1'b0;
            r_commit_err  <= 1'b0;
            r_query_valid <= 1'b0;
            r_alloc_slot  <= '0;
            r_alloc_addr  <= '0;
            r_query_m     <= '0;
            r_query_n     <= '0;
            r_query_addr  <= '0;
        end else begin
            r_alloc_valid <= 1'b0;
            r_alloc_err   <= 1'b0;
            r_commit_err  <= 1'b0;
            r_query_valid <= w_q_ok;
            r_query_m     <= w_q_ok ? r_m[w_qslot] : 4'd0;
            r_query_n     <= w_q_ok ? r_n[w_qslot] : 4'd0;
            r_query_addr  <= w_q_ok ? ADDR_WIDTH'(32'(query_slot) * SLOT_SIZE) : '0;
            if (clear_all) begin
                r_state    <= IDLE;
                r_valid    <= '0;
                r_reserved <= '0;
                for (int i = 0; i < NUM_SLOTS; i++) r_age[i] <= '0;
            end else begin
                if (commit_req) begin
                    if (w_commit_ok) begin
                        r_valid[w_cslot]    <= 1'b1;
                        r_reserved[w_cslot] <= 1'b0;
                        r_m[w_cslot]        <= commit_m;
                        r_n[w_cslot]        <= commit_n;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (SW'(i) == w_cslot) r_age[i] <= 8'd0;
                            else if (r_valid[i] && r_age[i] != 8'hff) r_age[i] <= r_age[i] + 8'd1;
                        end
                    end else begin
                        r_commit_err <= 1'b1;
                    end
                end
                case (r_state)
                    IDLE: if (alloc_req) begin
                        r_req_m     <= alloc_m;
                        r_req_n     <= alloc_n;
                        r_reserved  <= '0;
                        r_free_hit  <= 1'b0;
                        r_match_hit <= 1'b0;
                        r_old_hit   <= 1'b0;
                        r_match_cnt <= '0;
                        r_idx       <= '0;
                        r_state     <= SCAN;
                    end
                    SCAN: begin
                        if (!r_valid[r_idx] && !r_reserved[r_idx] && !r_free_hit) begin
                            r_free_hit <= 1'b1;
                            r_free_idx <= r_idx;
                        end
                        // strict > keeps the lowest index on age ties
                        if (w_cur_match) begin
                            r_match_cnt <= r_match_cnt + CW'(1);
                            if (!r_match_hit || r_age[r_idx] > r_match_age) begin
                                r_match_hit <= 1'b1;
                                r_match_idx <= r_idx;
                                r_match_age <= r_age[r_idx];
                            end
                        end
                        if (r_valid[r_idx] && (!r_old_hit || r_age[r_idx] > r_old_age)) begin
                            r_old_hit <= 1'b1;
                            r_old_idx <= r_idx;
                            r_old_age <= r_age[r_idx];
                        end
                        r_idx <= r_idx + SW'(1);
                        if (32'(r_idx) == NUM_SLOTS - 1) r_state <= DECIDE;
                    end
                    DECIDE: if (w_bad) begin
                        r_alloc_err <= 1'b1;
                        r_state     <= WAIT_RELEASE;
                    end else begin
                        r_alloc_valid        <= 1'b1;
                        r_alloc_slot         <= 4'(w_victim);
                        r_alloc_addr         <= ADDR_WIDTH'(32'(w_victim) * SLOT_SIZE);
                        r_valid[w_victim]    <= 1'b0;
                        r_reserved[w_victim] <= 1'b1;
                        r_state              <= GRANT;
                    end
                    GRANT:        r_state <= WAIT_RELEASE;
                    WAIT_RELEASE: if (!alloc_req) r_state <= IDLE;
                    default:      r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_matrix_slot_allocator.sv
// tb_matrix_slot_allocator: directed stimulus; alloc responses are checked by a queue-driven
// monitor for outcome, slot, address and arrival edge.
module tb_matrix_slot_allocator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] config_max_per_dim = '0;
    logic       clear_all = 1'b0;
    logic       alloc_req = 1'b0;
    logic [3:0] alloc_m = '0, alloc_n = '0;
    logic       alloc_valid, alloc_err;
    logic [3:0] alloc_slot;
    logic [9:0] alloc_addr;
    logic       commit_req = 1'b0;
    logic [3:0] commit_slot = '0, commit_m = '0, commit_n = '0;
    logic [9:0] commit_addr = '0;
    logic       commit_err;
    logic [3:0] query_slot = '0;
    logic       query_valid;
    logic [3:0] query_m, query_n;
    logic [9:0] query_addr;
    logic [7:0] slot_valid;
    logic       busy;

    matrix_slot_allocator #(.NUM_SLOTS(8), .SLOT_SIZE(32), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .config_max_per_dim(config_max_per_dim),
        .clear_all(clear_all), .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
        .alloc_valid(alloc_valid), .alloc_err(alloc_err), .alloc_slot(alloc_slot),
        .alloc_addr(alloc_addr), .commit_req(commit_req), .commit_slot(commit_slot),
        .commit_m(commit_m), .commit_n(commit_n), .commit_addr(commit_addr),
        .commit_err(commit_err), .query_slot(query_slot), .query_valid(query_valid),
        .query_m(query_m), .query_n(query_n), .query_addr(query_addr),
        .slot_valid(slot_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       err;
        logic [3:0] slot;
        logic [9:0] addr;
        int         at;
    } exp_t;
    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor: every alloc response must match the head of the expectation queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (alloc_valid || alloc_err)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_resp: valid=%0b err=%0b slot=%0d cyc=%0d",
                             alloc_valid, alloc_err, alloc_slot, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (alloc_err !== e.err || alloc_valid !== !e.err || cyc != e.at ||
                        (!e.err && (alloc_slot !== e.slot || alloc_addr !== e.addr))) begin
                        n_err++;
                        $display("FAIL alloc_resp: got v=%0b e=%0b slot=%0d addr=%0d cyc=%0d; expected e=%0b slot=%0d addr=%0d cyc=%0d",
                                 alloc_valid, alloc_err, alloc_slot, alloc_addr, cyc,
                                 e.err, e.slot, e.addr, e.at);
                    end
                end
            end
        end
    end

    task automatic push(input logic err, input logic [3:0] slot, input int at);
        exp_t e;
        e.err  = err;
        e.slot = slot;
        e.addr = 10'(slot * 32);
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_resp(input logic [7:0] exp_sv);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(alloc_valid || alloc_err) && k < 40);
        if (!(alloc_valid || alloc_err)) begin
            n_cmp++;
            n_err++;
            $display("FAIL alloc_timeout: no response within 40 cycles (cyc %0d)", cyc);
        end else begin
            chk("slot_valid_at_resp", 32'(slot_valid), 32'(exp_sv));
        end
        alloc_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_after_release", 32'(busy), 0);
    endtask

    task automatic do_alloc(input logic [3:0] m, input logic [3:0] n, input logic err,
                            input logic [3:0] slot, input logic [7:0] exp_sv);
        @(negedge clk);
        alloc_m   = m;
        alloc_n   = n;
        alloc_req = 1'b1;
        push(err, slot, cyc + 10);
        wait_resp(exp_sv);
    endtask

    task automatic do_commit(input logic [3:0] slot, input logic [3:0] m, input logic [3:0] n,
                             input logic exp_err);
        @(negedge clk);
        commit_req  = 1'b1;
        commit_slot = slot;
        commit_m    = m;
        commit_n    = n;
        commit_addr = 10'($urandom_range(0, 1023));
        @(negedge clk);
        commit_req = 1'b0;
        chk("commit_err", 32'(commit_err), 32'(exp_err));
    endtask

    task automatic do_query(input logic [3:0] slot, input logic v, input logic [3:0] m,
                            input logic [3:0] n, input logic [9:0] a);
        @(negedge clk);
        query_slot = slot;
        @(negedge clk);
        chk("query_valid", 32'(query_valid), 32'(v));
        chk("query_m", 32'(query_m), 32'(m));
        chk("query_n", 32'(query_n), 32'(n));
        chk("query_addr", 32'(query_addr), 32'(a));
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        chk("slot_valid_after_clear", 32'(slot_valid), 0);
    endtask

    logic [3:0] fill_m [8] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2};
    logic [3:0] fill_n [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2, 4'd3, 4'd4};

    initial begin
        int c0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_alloc_valid", 32'(alloc_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_slot_valid", 32'(slot_valid), 0);
        chk("rst_alloc_addr", 32'(alloc_addr), 0);
        chk("rst_query_valid", 32'(query_valid), 0);
        rst_n = 1'b1;

        // single alloc/commit/query; max 0 behaves as 1
        do_alloc(4'd2, 4'd3, 1'b0, 4'd0, 8'h00);
        do_commit(4'd0, 4'd2, 4'd3, 1'b0);
        chk("sv_after_commit0", 32'(slot_valid), 32'h01);
        do_query(4'd0, 1'b1, 4'd2, 4'd3, 10'd0);
        do_query(4'd9, 1'b0, 4'd0, 4'd0, 10'd0);
        do_alloc(4'd2, 4'd3, 1'b0, 4'd0, 8'h00);
        do_commit(4'd0, 4'd2, 4'd3, 1'b0);

        // per-shape quota of 2
        do_clear();
        config_max_per_dim = 4'd2;
        do_alloc(4'd2, 4'd2, 1'b0, 4'd0, 8'h00);
        do_commit(4'd0, 4'd2, 4'd2, 1'b0);
        do_alloc(4'd2, 4'd2, 1'b0, 4'd1, 8'h01);
        do_commit(4'd1, 4'd2, 4'd2, 1'b0);
        do_alloc(4'd2, 4'd2, 1'b0, 4'd0, 8'h02);
        do_commit(4'd0, 4'd2, 4'd2, 1'b0);
        do_alloc(4'd3, 4'd3, 1'b0, 4'd2, 8'h03);
        repeat (3) @(negedge clk);
        chk("alloc_addr_hold", 32'(alloc_addr), 64);
        do_commit(4'd2, 4'd3, 4'd3, 1'b0);
        chk("sv_three", 32'(slot_valid), 32'h07);

        // full table evicts the oldest overall
        do_clear();
        config_max_per_dim = 4'd4;
        for (int i = 0; i < 8; i++) begin
            do_alloc(fill_m[i], fill_n[i], 1'b0, 4'(i), 8'((1 << i) - 1));
            do_commit(4'(i), fill_m[i], fill_n[i], 1'b0);
        end
        chk("sv_full", 32'(slot_valid), 32'hff);
        do_alloc(4'd1, 4'd1, 1'b0, 4'd0, 8'hfe);

        // rejects
        do_alloc(4'd0, 4'd3, 1'b1, 4'd0, 8'hfe);
        do_alloc(4'd6, 4'd6, 1'b1, 4'd0, 8'hfe);
        do_commit(4'd5, 4'd1, 4'd1, 1'b1);
        chk("sv_after_bad_commit", 32'(slot_valid), 32'hfe);
        do_commit(4'd12, 4'd1, 4'd1, 1'b1);
        do_commit(4'd0, 4'd1, 4'd1, 1'b1);
        do_alloc(4'd4, 4'd8, 1'b0, 4'd0, 8'hfe);

        // clear_all beats a same-cycle commit
        @(negedge clk);
        commit_req  = 1'b1;
        commit_slot = 4'd0;
        clear_all   = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
        clear_all  = 1'b0;
        chk("commit_err_vs_clear", 32'(commit_err), 0);
        chk("sv_clear_vs_commit", 32'(slot_valid), 0);
        do_commit(4'd0, 4'd4, 4'd8, 1'b1);

        // clear_all mid-scan with request held: re-sampled on the next edge
        @(negedge clk);
        alloc_m   = 4'd2;
        alloc_n   = 4'd2;
        alloc_req = 1'b1;
        c0 = cyc;
        repeat (3) @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        chk("sv_clear_mid_scan", 32'(slot_valid), 0);
        chk("busy_clear_mid_scan", 32'(busy), 0);
        push(1'b0, 4'd0, c0 + 14);
        wait_resp(8'h00);

        // uncommitted reservation is released by the next request
        do_alloc(4'd5, 4'd5, 1'b0, 4'd0, 8'h00);
        do_commit(4'd0, 4'd5, 4'd5, 1'b0);
        do_alloc(4'd3, 4'd3, 1'b0, 4'd1, 8'h01);
        do_commit(4'd1, 4'd3, 4'd3, 1'b0);
        do_query(4'd1, 1'b1, 4'd3, 4'd3, 10'd32);

        // async reset mid-scan discards the request
        @(negedge clk);
        alloc_m   = 4'd1;
        alloc_n   = 4'd1;
        alloc_req = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_sv", 32'(slot_valid), 0);
        chk("rst_mid_alloc_addr", 32'(alloc_addr), 0);
        chk("rst_mid_query_valid", 32'(query_valid), 0);
        @(negedge clk);
        alloc_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("busy_after_rst", 32'(busy), 0);
        do_query(4'd1, 1'b0, 4'd0, 4'd0, 10'd0);
        do_alloc(4'd1, 4'd1, 1'b0, 4'd0, 8'h00);

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
